seq_adder_sched: RTL

- Round-robin scheduler that shares one 8-bit sequence adder (registered accumulator) between NREQ requesters.
- Each requester asks for the sum of a burst of operands. The scheduler grants one requester at a time, clears the adder, and streams that requester's operands into it one per cycle.
- On completion it returns the final sum with a done pulse.
- Sits between the requester blocks and the shared adder instance.

---
 rtl/seq_adder_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_adder_sched.sv
// Round-robin scheduler that time-shares one external accumulator among NREQ requesters.
// Define SEQ_ADDER_SCHED_OVF_EN to add the ovf output (driven from a widened shadow sum).
module seq_adder_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LENW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*W-1:0]    req_data,
    output logic [NREQ-1:0]      take,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [W-1:0]         result,
    output logic                 busy,
    output logic [W-1:0]         add_a,
    output logic                 add_clr,
    input  logic [W-1:0]         add_q
`ifdef SEQ_ADDER_SCHED_OVF_EN
    ,
    output logic                 ovf
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_WAIT, S_DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_ptr_q, g_q, sel_d;
    logic            found_d;
    logic [LENW-1:0] len_q, count_q;
    logic [NREQ-1:0] gnt_q, take_q, done_q;
    logic [W-1:0]    result_q;
    logic            add_clr_q;

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        sel_d   = '0;
        found_d = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_d && req[(int'(rr_ptr_q) + k) % NREQ]) begin
                found_d = 1'b1;
                sel_d   = IW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            g_q       <= '0;
            len_q     <= '0;
            count_q   <= '0;
            gnt_q     <= '0;
            take_q    <= '0;
            done_q    <= '0;
            result_q  <= '0;
            add_clr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        g_q       <= sel_d;
                        len_q     <= req_len[sel_d*LENW +: LENW];
                        gnt_q     <= NREQ'(1) << sel_d;
                        add_clr_q <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    add_clr_q <= 1'b0;
                    count_q   <= '0;
                    if (len_q != '0) begin
                        take_q  <= NREQ'(1) << g_q;
                        state_q <= S_ACCUM;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_ACCUM: begin
                    count_q <= count_q + LENW'(1);
                    if (count_q == len_q - LENW'(1)) begin
                        take_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    result_q <= add_q;
                    done_q   <= NREQ'(1) << g_q;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q   <= '0;
                    gnt_q    <= '0;
                    rr_ptr_q <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operand is passed straight through so the requester's next word lines up with its take.
    assign add_a   = (take_q != '0) ? req_data[g_q*W +: W] : '0;
    assign take    = take_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign result  = result_q;
    assign busy    = (state_q != S_IDLE);
    assign add_clr = add_clr_q;

`ifdef SEQ_ADDER_SCHED_OVF_EN
    logic [W+LENW-1:0] shadow_q;
    logic              ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == S_CLEAR)
                shadow_q <= '0;
            else if (state_q == S_ACCUM)
                shadow_q <= shadow_q + (W+LENW)'(add_a);
            ovf_q <= (state_q == S_WAIT) ? |shadow_q[W+LENW-1:W] : 1'b0;
        end
    end

    assign ovf = ovf_q;
`endif
endmodule
